// File: rtl/codificador_de_comando_pkg.sv
// Shared types and constants for the station command encoder.
package comando_pkg;

    localparam int USER_W = 3;
    localparam int FUNC_W = 3;

    localparam logic [USER_W-1:0] USER_PILOTO = 3'b111;
    localparam logic [USER_W-1:0] USER_NEUTRO = 3'b000;
    localparam logic [FUNC_W-1:0] FUNC_NEUTRO = 3'b000;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        OFFER
    } state_t;

endpackage

// File: rtl/codificador_de_comando_debouncer.sv
// Single-bit debouncer: the output follows the input only after the input has
// held a value different from the output for DEB_CYCLES consecutive cycles.
module debouncer #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic sample_in,
    output logic stable_out
);

    localparam int               CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sample_in == stable_q) begin
            // Sample agrees with the accepted level (or bounced back): restart the run.
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            stable_d = sample_in;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_out = stable_q;

endmodule

// File: rtl/codificador_de_comando.sv
// One user station: synchronizes and debounces the panel and turns a button gesture
// into a registered {User, Func} Valid/Ready command. Optional offer timeout: CMD_TIMEOUT_EN.
module codificador_de_comando
    import comando_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int DEB_CYCLES     = 250000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [USER_W-1:0] User_In,
    input  logic              Func_Hi,
    input  logic [1:0]        BTN_N,
    input  logic              Ready,
    output logic              Valid,
    output logic [USER_W-1:0] User,
    output logic [FUNC_W-1:0] Func,
    output logic              Busy,
    output logic              Drop
);

    localparam int               RAW_W     = USER_W + 1 + 2;
    localparam logic [RAW_W-1:0] RAW_RESET = {{USER_W{1'b0}}, 1'b0, 2'b11};

    logic [RAW_W-1:0] sync_q [SYNC_STAGES];
    logic [RAW_W-1:0] sync_d [SYNC_STAGES];

    always_comb begin
        sync_d[0] = {User_In, Func_Hi, BTN_N};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= RAW_RESET;
            end
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    logic [USER_W-1:0] user_sync;
    logic              func_hi_sync;
    logic [1:0]        pressed;
    logic [1:0]        deb;

    assign user_sync    = sync_q[SYNC_STAGES-1][RAW_W-1 -: USER_W];
    assign func_hi_sync = sync_q[SYNC_STAGES-1][2];
    assign pressed      = ~sync_q[SYNC_STAGES-1][1:0];

    for (genvar b = 0; b < 2; b++) begin : g_deb
        debouncer #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk       (CLK),
            .rst       (RST),
            .sample_in (pressed[b]),
            .stable_out(deb[b])
        );
    end

    state_t            state_q, state_d;
    logic [1:0]        acc_q, acc_d;
    logic              valid_q, valid_d;
    logic [USER_W-1:0] user_q, user_d;
    logic [FUNC_W-1:0] func_q, func_d;
    logic              busy_q, busy_d;

`ifdef CMD_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             drop_q, drop_d;
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        valid_d = valid_q;
        user_d  = user_q;
        func_d  = func_q;
`ifdef CMD_TIMEOUT_EN
        tmo_d   = tmo_q;
        drop_d  = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (deb != 2'b00) begin
                    state_d = ARMED;
                    acc_d   = deb;
                end
            end
            ARMED: begin
                acc_d = acc_q | deb;
                if (deb == 2'b00) begin
                    // Last debounced release: freeze the panel into the command.
                    state_d = OFFER;
                    user_d  = user_sync;
                    func_d  = {func_hi_sync, acc_q};
                    valid_d = 1'b1;
`ifdef CMD_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            OFFER: begin
                if (valid_q && Ready) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    acc_d   = 2'b00;
                end
`ifdef CMD_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_d = IDLE;
                    valid_d = 1'b0;
                    acc_d   = 2'b00;
                    drop_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            acc_q   <= 2'b00;
            valid_q <= 1'b0;
            user_q  <= USER_NEUTRO;
            func_q  <= FUNC_NEUTRO;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            valid_q <= valid_d;
            user_q  <= user_d;
            func_q  <= func_d;
            busy_q  <= busy_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            tmo_q  <= tmo_d;
            drop_q <= drop_d;
        end
    end

    assign Drop = drop_q;
`else
    assign Drop = 1'b0;
`endif

    assign Valid = valid_q;
    assign User  = user_q;
    assign Func  = func_q;
    assign Busy  = busy_q;

endmodule
